// File: rtl/instr_cache_if.sv
// Refill port of instr_cache: word-wide read requests with a req/ack handshake.
interface instr_cache_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with combinational hit path and a
// word-by-word line refill FSM.
// Optional feature: define INSTR_CACHE_PERF_EN to add hit_count/miss_count ports.
module instr_cache #(
  parameter int unsigned LINES      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc,
  input  logic          inv,
  output logic [31:0]   instr,
  output logic          hit,
  instr_cache_if.master mem
`ifdef INSTR_CACHE_PERF_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int unsigned OFF       = $clog2(LINE_WORDS);
  localparam int unsigned IDX       = $clog2(LINES);
  localparam int unsigned TAG_LSB   = OFF + IDX + 2;
  localparam int unsigned TAG_W     = 32 - TAG_LSB;
  localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);
  localparam logic [31:0]    BASE_MASK = ~32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, REFILL, FILLED} state_t;

  state_t             state_q, state_d;
  logic [OFF-1:0]     cnt_q, cnt_d;
  logic [31:0]        base_q, base_d;
  logic               inv_pend_q, inv_pend_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               fill_we, tag_we, miss;

  logic [31:0]        data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0]   tag_q  [LINES];

  logic [OFF-1:0]     pc_off;
  logic [IDX-1:0]     pc_idx, base_idx;
  logic [TAG_W-1:0]   pc_tag, base_tag;
  logic               unused_pc_bits;

  assign pc_off         = pc[OFF+1:2];
  assign pc_idx         = pc[TAG_LSB-1:OFF+2];
  assign pc_tag         = pc[31:TAG_LSB];
  assign base_idx       = base_q[TAG_LSB-1:OFF+2];
  assign base_tag       = base_q[31:TAG_LSB];
  assign unused_pc_bits = ^pc[1:0];

  // Lookup: a pending invalidate masks the hit in the same cycle.
  assign hit   = (state_q == IDLE) && !inv && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign instr = hit ? data_q[pc_idx][pc_off] : 32'h0;

  assign mem.mem_req  = (state_q == REFILL);
  assign mem.mem_addr = (state_q == REFILL) ? base_q + 32'({cnt_q, 2'b00}) : 32'h0;

  // Next-state and refill control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    inv_pend_d = inv_pend_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    miss       = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv) begin
          valid_d = '0;
        end else if (!hit) begin
          miss    = 1'b1;
          base_d  = pc & BASE_MASK;
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (inv) inv_pend_d = 1'b1;
        if (mem.mem_ack) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + OFF'(1);
          if (cnt_q == LAST_WORD) begin
            tag_we     = 1'b1;
            inv_pend_d = 1'b0;
            state_d    = FILLED;
            if (inv_pend_q || inv) valid_d = '0;
            else                   valid_d[base_idx] = 1'b1;
          end
        end
      end
      FILLED: begin
        // The refill has already completed, so an invalidate here acts at once.
        state_d = IDLE;
        if (inv) valid_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      inv_pend_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      inv_pend_q <= inv_pend_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data arrays (not reset; guarded by the valid bits).
  always_ff @(posedge clk) begin
    if (!rst && fill_we) data_q[base_idx][cnt_q] <= mem.mem_rdata;
    if (!rst && tag_we)  tag_q[base_idx]         <= base_tag;
  end

`ifdef INSTR_CACHE_PERF_EN
  // Free-running hit/miss event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus a randomized
// fetch stream checked against a line-level valid/tag model.
module tb_instr_cache;
  localparam int unsigned LINES      = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned OFF        = $clog2(LINE_WORDS);
  localparam int unsigned IDX        = $clog2(LINES);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv = 1'b0;
  logic [31:0] pc  = 32'h0;
  logic [31:0] instr;
  logic        hit;
`ifdef INSTR_CACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  instr_cache_if mem_if ();

  instr_cache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc    (pc),
    .inv   (inv),
    .instr (instr),
    .hit   (hit),
    .mem   (mem_if)
`ifdef INSTR_CACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory responder state: 0 zero-wait, 1 ack every third cycle, 2 random.
  int          wait_mode = 0;
  bit          spurious  = 1'b0;
  int          streak    = 0;
  logic        rsp_ack;
  logic [31:0] log_addr[$];
  bit          log_ack[$];

  // Line-level reference model.
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h40) >> 2);
  endfunction

  // Instruction memory: answers requests and logs every request cycle.
  always @(negedge clk) begin
    if (mem_if.mem_req) begin
      case (wait_mode)
        0: rsp_ack = 1'b1;
        1: begin
          rsp_ack = (streak == 2);
          streak  = rsp_ack ? 0 : streak + 1;
        end
        default: rsp_ack = ($urandom_range(2) != 0);
      endcase
      log_addr.push_back(mem_if.mem_addr);
      log_ack.push_back(rsp_ack);
    end else begin
      streak  = 0;
      rsp_ack = spurious && ($urandom_range(1) == 1);
    end
    mem_if.mem_ack   = rsp_ack;
    mem_if.mem_rdata = (rsp_ack && mem_if.mem_req) ? mem_word(mem_if.mem_addr) : $urandom;
  end

  // Number of deviations of the logged refill from base, base+4, ... with
  // the address held until each ack and exactly LINE_WORDS acks.
  function automatic int addr_errs(input logic [31:0] base);
    int k = 0;
    int e = 0;
    foreach (log_addr[j]) begin
      if (log_addr[j] !== base + 32'(4 * k)) e++;
      if (log_ack[j]) k++;
    end
    if (k != LINE_WORDS) e++;
    return e;
  endfunction

  task automatic wait_hit(input int max_c, output int stalls, output logic [31:0] got);
    stalls = 0;
    got    = 32'h0;
    while (1) begin
      @(negedge clk);
      if (hit === 1'b1) begin
        got = instr;
        break;
      end
      stalls++;
      if (stalls > max_c) begin
        tests++; fails++;
        $display("FAIL hit_timeout pc=%h after %0d cycles", pc, stalls);
        break;
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int max_c, output int stalls, output logic [31:0] got);
    @(posedge clk); #1;
    rst = 1'b0; inv = 1'b0; pc = a;
    log_addr.delete(); log_ack.delete();
    wait_hit(max_c, stalls, got);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (hit !== 1'b0) begin fails++; $display("FAIL rst_hit got=%b exp=0", hit); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr got=%h exp=0", instr); end
    tests++; if (mem_if.mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", mem_if.mem_req); end
    tests++; if (mem_if.mem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", mem_if.mem_addr); end
`ifdef INSTR_CACHE_PERF_EN
    tests++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      fails++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_cold_miss();
    int st; logic [31:0] got;
    wait_mode = 0;
    fetch(32'h40, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL cold_stall got=%0d exp=6", st); end
    tests++; if (got !== 32'hA0) begin fails++; $display("FAIL cold_instr got=%h exp=a0", got); end
    tests++; if (addr_errs(32'h40) !== 0 || log_addr.size() !== 4) begin
      fails++; $display("FAIL cold_addrs errs=%0d reqs=%0d exp=0/4", addr_errs(32'h40), log_addr.size());
    end
    fetch(32'h4C, 50, st, got);
    tests++; if (st !== 0) begin fails++; $display("FAIL cold_hit_stall got=%0d exp=0", st); end
    tests++; if (got !== 32'hA3) begin fails++; $display("FAIL cold_hit_instr got=%h exp=a3", got); end
  endtask

  task automatic test_conflict();
    int st; logic [31:0] got;
    fetch(32'h140, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL conf_stall got=%0d exp=6", st); end
    tests++; if (got !== mem_word(32'h140)) begin fails++; $display("FAIL conf_instr got=%h exp=%h", got, mem_word(32'h140)); end
    tests++; if (addr_errs(32'h140) !== 0) begin fails++; $display("FAIL conf_addrs errs=%0d exp=0", addr_errs(32'h140)); end
    fetch(32'h44, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL conf_back_stall got=%0d exp=6", st); end
    tests++; if (got !== 32'hA1) begin fails++; $display("FAIL conf_back_instr got=%h exp=a1", got); end
  endtask

  task automatic test_wait_states();
    int st; logic [31:0] got;
    wait_mode = 1;
    fetch(32'h88, 80, st, got);
    tests++; if (log_addr.size() !== 12) begin fails++; $display("FAIL wait_req_cycles got=%0d exp=12", log_addr.size()); end
    tests++; if (addr_errs(32'h80) !== 0) begin fails++; $display("FAIL wait_addr_hold errs=%0d exp=0", addr_errs(32'h80)); end
    tests++; if (st !== 14) begin fails++; $display("FAIL wait_stall got=%0d exp=14", st); end
    tests++; if (got !== mem_word(32'h88)) begin fails++; $display("FAIL wait_instr got=%h exp=%h", got, mem_word(32'h88)); end
    wait_mode = 0;
  endtask

  task automatic test_inv_idle();
    int st; logic [31:0] got;
    fetch(32'h40, 50, st, got);
    tests++; if (st !== 0) begin fails++; $display("FAIL invi_prehit got=%0d exp=0", st); end
    @(posedge clk); #1 inv = 1'b1;
    @(negedge clk);
    tests++; if (hit !== 1'b0 || instr !== 32'h0) begin fails++; $display("FAIL invi_mask hit=%b instr=%h exp=0/0", hit, instr); end
    tests++; if (mem_if.mem_req !== 1'b0) begin fails++; $display("FAIL invi_req got=%b exp=0", mem_if.mem_req); end
    fetch(32'h40, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL invi_refetch_stall got=%0d exp=6", st); end
    fetch(32'h80, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL invi_other_stall got=%0d exp=6", st); end
  endtask

  task automatic test_inv_refill();
    int st; logic [31:0] got;
    @(posedge clk); #1;
    pc = 32'hC4; log_addr.delete(); log_ack.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 inv = 1'b1;
    @(posedge clk); #1 inv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tests++; if (hit !== 1'b0 || mem_if.mem_req !== 1'b0) begin
      fails++; $display("FAIL invr_filled hit=%b req=%b exp=0/0", hit, mem_if.mem_req);
    end
    log_addr.delete(); log_ack.delete();
    wait_hit(50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL invr_refetch_stall got=%0d exp=6", st); end
    tests++; if (addr_errs(32'hC0) !== 0) begin fails++; $display("FAIL invr_refetch_addrs errs=%0d exp=0", addr_errs(32'hC0)); end
    tests++; if (got !== mem_word(32'hC4)) begin fails++; $display("FAIL invr_instr got=%h exp=%h", got, mem_word(32'hC4)); end
    fetch(32'h80, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL invr_other_stall got=%0d exp=6", st); end
  endtask

  task automatic test_reset_mid_refill();
    int st; logic [31:0] got;
    @(posedge clk); #1;
    pc = 32'h108;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (mem_if.mem_req !== 1'b0 || hit !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort req=%b hit=%b exp=0/0", mem_if.mem_req, hit);
    end
    fetch(32'h108, 50, st, got);
    tests++; if (st !== 6) begin fails++; $display("FAIL rstmid_stall got=%0d exp=6", st); end
    tests++; if (addr_errs(32'h100) !== 0) begin fails++; $display("FAIL rstmid_addrs errs=%0d exp=0", addr_errs(32'h100)); end
    tests++; if (got !== mem_word(32'h108)) begin fails++; $display("FAIL rstmid_instr got=%h exp=%h", got, mem_word(32'h108)); end
  endtask

  task automatic test_random();
    int st; logic [31:0] got, a, t; int i;
    pulse_reset();
    foreach (mvalid[k]) mvalid[k] = 1'b0;
    wait_mode = 2; spurious = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(2)) << (OFF + IDX + 2)) | (32'($urandom_range(5)) << (OFF + 2))
        | (32'($urandom_range(LINE_WORDS - 1)) << 2);
      i = int'((a >> (OFF + 2)) % LINES);
      t = a >> (OFF + IDX + 2);
      if ($urandom_range(7) == 0 && n > 0) begin
        @(posedge clk); #1 inv = 1'b1;
        @(negedge clk);
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL rnd_inv_mask n=%0d hit=%b exp=0", n, hit); end
        foreach (mvalid[k]) mvalid[k] = 1'b0;
      end
      fetch(a, 200, st, got);
      if (mvalid[i] && mtag[i] == t) begin
        tests++; if (st !== 0) begin fails++; $display("FAIL rnd_hit_stall a=%h got=%0d exp=0", a, st); end
      end else begin
        tests++; if (st !== 2 + log_addr.size()) begin
          fails++; $display("FAIL rnd_miss_stall a=%h got=%0d exp=%0d", a, st, 2 + log_addr.size());
        end
        tests++; if (addr_errs(a & ~32'(LINE_WORDS * 4 - 1)) !== 0) begin
          fails++; $display("FAIL rnd_addrs a=%h errs=%0d exp=0", a, addr_errs(a & ~32'(LINE_WORDS * 4 - 1)));
        end
        mvalid[i] = 1'b1;
        mtag[i]   = t;
      end
      tests++; if (got !== mem_word(a)) begin fails++; $display("FAIL rnd_instr a=%h got=%h exp=%h", a, got, mem_word(a)); end
    end
    wait_mode = 0; spurious = 1'b0;
  endtask

`ifdef INSTR_CACHE_PERF_EN
  task automatic test_perf();
    int st; logic [31:0] got;
    pulse_reset();
    fetch(32'h200, 50, st, got);
    fetch(32'h200, 50, st, got);
    fetch(32'h204, 50, st, got);
    @(posedge clk); #1 inv = 1'b1;
    @(negedge clk);
    tests++; if (miss_count !== 32'd1) begin fails++; $display("FAIL perf_miss got=%0d exp=1", miss_count); end
    tests++; if (hit_count !== 32'd3) begin fails++; $display("FAIL perf_hit got=%0d exp=3", hit_count); end
    @(posedge clk); #1 inv = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_wait_states();
    test_inv_idle();
    test_inv_refill();
    test_reset_mid_refill();
    test_random();
`ifdef INSTR_CACHE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
